// File: rtl/sdpram_stream_fifo.sv
// Stream FIFO controller around an external simple dual-port RAM with a fixed read latency.
// A credit-limited skid buffer absorbs the read pipeline so the output side can stall freely.
module sdpram_stream_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int MEM_DEPTH  = 16,
    parameter int ADDR_WIDTH = $clog2(MEM_DEPTH),
    parameter int RD_LATENCY = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  ram_wena,
    output logic [ADDR_WIDTH-1:0] ram_addra,
    output logic [DATA_WIDTH-1:0] ram_dina,
    output logic                  ram_renb,
    output logic [ADDR_WIDTH-1:0] ram_addrb,
    input  logic [DATA_WIDTH-1:0] ram_doutb,
    output logic [ADDR_WIDTH:0]   level
);

    localparam int BUF_DEPTH = RD_LATENCY + 1;
    localparam int BIDX_W    = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W     = ADDR_WIDTH + 1;

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [CNT_W-1:0]      ram_cnt;
    logic [CNT_W-1:0]      buf_cnt;
    logic [CNT_W-1:0]      inflight;
    logic [CNT_W-1:0]      credit_used;
    logic [RD_LATENCY-1:0] tag;
    logic [DATA_WIDTH-1:0] buf_mem [BUF_DEPTH];
    logic [BIDX_W-1:0]     buf_wr;
    logic [BIDX_W-1:0]     buf_rd;
    logic                  wr;
    logic                  issue;
    logic                  pop;
    logic                  capture;

    function automatic logic [BIDX_W-1:0] next_bidx(input logic [BIDX_W-1:0] idx);
        if (idx == BIDX_W'(BUF_DEPTH - 1))
            return '0;
        return idx + BIDX_W'(1);
    endfunction

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++)
            inflight = inflight + CNT_W'(tag[i]);
    end

    assign s_ready     = (ram_cnt < CNT_W'(MEM_DEPTH)) && !rst;
    assign wr          = s_valid && s_ready;
    assign m_valid     = (buf_cnt != '0) && !rst;
    assign pop         = m_valid && m_ready;
    // Every issued read owns a buffer slot from issue until pop, so the buffer cannot overflow.
    assign credit_used = inflight + buf_cnt - CNT_W'(pop);
    assign issue       = (ram_cnt != '0) && (credit_used < CNT_W'(BUF_DEPTH)) && !rst;
    assign capture     = tag[RD_LATENCY-1];

    assign ram_wena  = wr;
    assign ram_addra = rst ? '0 : wr_ptr;
    assign ram_dina  = s_data;
    // The RAM read pipeline only advances while enabled, so it stays on outside reset.
    assign ram_renb  = !rst;
    assign ram_addrb = rst ? '0 : rd_ptr;
    assign m_data    = rst ? '0 : buf_mem[buf_rd];
    assign level     = rst ? '0 : (ram_cnt + inflight + buf_cnt);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            ram_cnt <= '0;
            buf_cnt <= '0;
            buf_wr  <= '0;
            buf_rd  <= '0;
            tag     <= '0;
        end else begin
            if (wr)
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            if (issue)
                rd_ptr <= rd_ptr + ADDR_WIDTH'(1);

            case ({wr, issue})
                2'b10:   ram_cnt <= ram_cnt + CNT_W'(1);
                2'b01:   ram_cnt <= ram_cnt - CNT_W'(1);
                default: ram_cnt <= ram_cnt;
            endcase

            tag[0] <= issue;
            for (int i = 1; i < RD_LATENCY; i++)
                tag[i] <= tag[i-1];

            if (capture)
                buf_wr <= next_bidx(buf_wr);
            if (pop)
                buf_rd <= next_bidx(buf_rd);

            case ({capture, pop})
                2'b10:   buf_cnt <= buf_cnt + CNT_W'(1);
                2'b01:   buf_cnt <= buf_cnt - CNT_W'(1);
                default: buf_cnt <= buf_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && capture)
            buf_mem[buf_wr] <= ram_doutb;
    end

endmodule

// File: tb/tb_sdpram_stream_fifo.sv
// Directed bench for sdpram_stream_fifo: per-cycle vector table, then multi-cycle sequences
// checked by a queue scoreboard. Includes a behavioural model of the latency-3 RAM.
module tb_sdpram_stream_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] s_data;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;
    logic       ram_wena;
    logic [3:0] ram_addra;
    logic [7:0] ram_dina;
    logic       ram_renb;
    logic [3:0] ram_addrb;
    logic [7:0] ram_doutb;
    logic [4:0] level;

    always #5 clk = ~clk;

    sdpram_stream_fifo #(
        .DATA_WIDTH(8), .MEM_DEPTH(16), .ADDR_WIDTH(4), .RD_LATENCY(3)
    ) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .ram_wena(ram_wena), .ram_addra(ram_addra), .ram_dina(ram_dina),
        .ram_renb(ram_renb), .ram_addrb(ram_addrb), .ram_doutb(ram_doutb),
        .level(level)
    );

    logic [7:0] mem [16];
    logic [7:0] rpipe [3];
    always @(posedge clk) begin
        if (ram_wena)
            mem[ram_addra] <= ram_dina;
        if (ram_renb) begin
            rpipe[0] <= mem[ram_addrb];
            rpipe[1] <= rpipe[0];
            rpipe[2] <= rpipe[1];
        end
    end
    assign ram_doutb = rpipe[2];

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor, sampling mid-cycle on the falling edge.
    logic [7:0] q[$];
    bit         mon_en = 0;
    int         cyc = 0;
    int         ph_push, ph_pop, first_push_cyc, first_pop_cyc, last_pop_cyc;
    logic [7:0] last_pop_data;
    bit         have_prev = 0;
    bit         prev_hold;
    logic [7:0] prev_data;

    always @(negedge clk) begin
        cyc++;
        if (mon_en) begin
            if (rst) begin
                q.delete();
                have_prev = 0;
            end else begin
                check("mon level", int'(level), q.size());
                n_chk++;
                if (level > 5'd20) begin
                    n_err++;
                    $display("FAIL mon level_max: got %0d expected <= 20", level);
                end
                if (have_prev && prev_hold)
                    check("mon m_data hold", int'(m_data), int'(prev_data));
                if (m_valid && m_ready) begin
                    if (q.size() == 0) begin
                        n_chk++;
                        n_err++;
                        $display("FAIL mon pop_empty: got data 0x%0h expected no output", m_data);
                    end else begin
                        check("mon order", int'(m_data), int'(q.pop_front()));
                    end
                    if (ph_pop == 0)
                        first_pop_cyc = cyc;
                    last_pop_cyc  = cyc;
                    last_pop_data = m_data;
                    ph_pop++;
                end
                if (s_valid && s_ready) begin
                    q.push_back(s_data);
                    if (ph_push == 0)
                        first_push_cyc = cyc;
                    ph_push++;
                end
                prev_hold = m_valid && !m_ready;
                prev_data = m_data;
                have_prev = 1;
            end
        end
    end

    typedef struct {
        bit       rst;
        bit       sv;
        bit [7:0] sd;
        bit       mr;
        bit       e_sready;
        bit       e_mvalid;
        bit [7:0] e_mdata;
        int       e_level;
        bit       e_wena;
        int       e_addra;
        int       e_addrb;
        bit       e_renb;
    } vec_t;

    vec_t vq[$];

    task automatic add(input bit r, input bit sv, input bit [7:0] sd, input bit mr,
                       input bit er, input bit emv, input bit [7:0] emd, input int elv,
                       input bit ew, input int ea, input int eb, input bit ern);
        vec_t v;
        v.rst = r; v.sv = sv; v.sd = sd; v.mr = mr;
        v.e_sready = er; v.e_mvalid = emv; v.e_mdata = emd; v.e_level = elv;
        v.e_wena = ew; v.e_addra = ea; v.e_addrb = eb; v.e_renb = ern;
        vq.push_back(v);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_phase();
        ph_push = 0;
        ph_pop  = 0;
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while (q.size() != 0 && n < budget) begin
            next_cycle();
            n++;
        end
        n_chk++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL %s timeout: got %0d words left expected 0", name, q.size());
        end
        @(negedge clk);
        check({name, " level"}, int'(level), 0);
        check({name, " m_valid"}, int'(m_valid), 0);
        next_cycle();
    endtask

    initial begin
        int i, n;
        bit acc;

        //   rst sv  sd    mr | rdy mv mdata lvl wena addra addrb renb
        add(1, 1, 8'h11, 0,   0, 0, 8'h00, 0, 0, 0, 0, 0);
        add(1, 1, 8'h11, 0,   0, 0, 8'h00, 0, 0, 0, 0, 0);
        add(1, 1, 8'h11, 0,   0, 0, 8'h00, 0, 0, 0, 0, 0);
        add(0, 0, 8'h00, 1,   1, 0, 8'h00, 0, 0, 0, 0, 1);
        add(0, 1, 8'hA5, 1,   1, 0, 8'h00, 0, 1, 0, 0, 1);
        add(0, 0, 8'h00, 1,   1, 0, 8'h00, 1, 0, 1, 0, 1);
        add(0, 0, 8'h00, 1,   1, 0, 8'h00, 1, 0, 1, 1, 1);
        add(0, 0, 8'h00, 1,   1, 0, 8'h00, 1, 0, 1, 1, 1);
        add(0, 0, 8'h00, 1,   1, 0, 8'h00, 1, 0, 1, 1, 1);
        add(0, 0, 8'h00, 1,   1, 1, 8'hA5, 1, 0, 1, 1, 1);
        add(0, 0, 8'h00, 1,   1, 0, 8'h00, 0, 0, 1, 1, 1);
        add(0, 1, 8'h3C, 0,   1, 0, 8'h00, 0, 1, 1, 1, 1);
        add(0, 1, 8'hC3, 0,   1, 0, 8'h00, 1, 1, 2, 1, 1);
        add(0, 0, 8'h00, 0,   1, 0, 8'h00, 2, 0, 3, 2, 1);
        add(0, 0, 8'h00, 0,   1, 0, 8'h00, 2, 0, 3, 3, 1);
        add(0, 0, 8'h00, 0,   1, 0, 8'h00, 2, 0, 3, 3, 1);
        add(0, 0, 8'h00, 0,   1, 1, 8'h3C, 2, 0, 3, 3, 1);
        add(0, 0, 8'h00, 0,   1, 1, 8'h3C, 2, 0, 3, 3, 1);
        add(0, 0, 8'h00, 1,   1, 1, 8'h3C, 2, 0, 3, 3, 1);
        add(0, 0, 8'h00, 1,   1, 1, 8'hC3, 1, 0, 3, 3, 1);
        add(0, 0, 8'h00, 1,   1, 0, 8'h00, 0, 0, 3, 3, 1);

        for (int r = 0; r < vq.size(); r++) begin
            rst = vq[r].rst; s_valid = vq[r].sv; s_data = vq[r].sd; m_ready = vq[r].mr;
            @(negedge clk);
            check($sformatf("row%0d s_ready", r), int'(s_ready), int'(vq[r].e_sready));
            check($sformatf("row%0d m_valid", r), int'(m_valid), int'(vq[r].e_mvalid));
            if (vq[r].e_mvalid)
                check($sformatf("row%0d m_data", r), int'(m_data), int'(vq[r].e_mdata));
            check($sformatf("row%0d level", r), int'(level), vq[r].e_level);
            check($sformatf("row%0d ram_wena", r), int'(ram_wena), int'(vq[r].e_wena));
            check($sformatf("row%0d ram_addra", r), int'(ram_addra), vq[r].e_addra);
            check($sformatf("row%0d ram_addrb", r), int'(ram_addrb), vq[r].e_addrb);
            check($sformatf("row%0d ram_renb", r), int'(ram_renb), int'(vq[r].e_renb));
            next_cycle();
        end

        s_valid = 0; m_ready = 0; s_data = 0;
        mon_en = 1;

        // Fill under backpressure: 16 in RAM plus 4 in the skid buffer.
        reset_phase();
        i = 0; n = 0;
        while (i < 20 && n < 200) begin
            s_valid = 1; s_data = 8'(i);
            @(negedge clk);
            acc = s_ready;
            next_cycle();
            if (acc) i++;
            n++;
        end
        s_valid = 0;
        check("fill accepted", i, 20);
        repeat (8) next_cycle();
        @(negedge clk);
        check("fill level", int'(level), 20);
        check("fill s_ready", int'(s_ready), 0);
        check("fill m_data head", int'(m_data), 0);
        next_cycle();
        m_ready = 1;
        drain("fill drain", 100);
        check("fill pops", ph_pop, 20);

        // Streaming with pointer wrap.
        reset_phase();
        for (int k = 0; k < 64; k++) begin
            s_valid = 1; s_data = 8'(8'h40 + k); m_ready = 1;
            @(negedge clk);
            check("stream s_ready", int'(s_ready), 1);
            next_cycle();
        end
        s_valid = 0;
        drain("stream drain", 50);
        check("stream pops", ph_pop, 64);
        check("stream latency", first_pop_cyc - first_push_cyc, 5);
        check("stream gapless", last_pop_cyc - first_pop_cyc, 63);

        // Random valid/ready at 50%.
        reset_phase();
        i = 0; n = 0;
        while (i < 1000 && n < 20000) begin
            s_valid = 1'($urandom % 2); m_ready = 1'($urandom % 2); s_data = 8'(i);
            @(negedge clk);
            acc = s_valid && s_ready;
            next_cycle();
            if (acc) i++;
            n++;
        end
        s_valid = 0; m_ready = 1;
        check("random accepted", i, 1000);
        drain("random drain", 100);
        check("random pops", ph_pop, 1000);

        // Reset with ten words held.
        reset_phase();
        m_ready = 0;
        for (int k = 0; k < 10; k++) begin
            s_valid = 1; s_data = 8'(8'h80 + k);
            next_cycle();
        end
        s_valid = 0;
        repeat (6) next_cycle();
        @(negedge clk);
        check("midrst level before", int'(level), 10);
        next_cycle();
        rst = 1;
        @(negedge clk);
        check("midrst m_valid in reset", int'(m_valid), 0);
        check("midrst s_ready in reset", int'(s_ready), 0);
        next_cycle();
        next_cycle();
        rst = 0;
        @(negedge clk);
        check("midrst level after", int'(level), 0);
        check("midrst m_valid after", int'(m_valid), 0);
        check("midrst s_ready after", int'(s_ready), 1);
        next_cycle();
        reset_phase();
        s_valid = 1; s_data = 8'h5A; m_ready = 1;
        next_cycle();
        s_valid = 0;
        n = 0;
        while (ph_pop == 0 && n < 20) begin
            next_cycle();
            n++;
        end
        check("midrst first pop seen", ph_pop, 1);
        check("midrst first word", int'(last_pop_data), 8'h5A);
        drain("midrst drain", 20);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
